prog_loader_rom: RTL and testbench

Upstream instruction source for the 4-bit CPU core. Holds a 16 x 8-bit writable program store, loaded byte-by-byte over a valid/ready handshake while the core is held in reset. Releases the core and serves `instr = mem[address]` combinationally, so the core's zero-latency fetch timing is preserved. Also provides a running XOR checksum of the loaded image for bring-up.

---
 rtl/prog_loader_rom_pkg.sv | 16 +
 rtl/prog_store.sv | 30 +++
 rtl/prog_loader_rom.sv | 98 +++++++++
 tb/tb_prog_loader_rom.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_rom_pkg.sv
// rtl/prog_loader_rom_pkg.sv - shared widths, NOP and loader state encoding
package prog_loader_rom_pkg;

  localparam int PL_ADDR_W = 4;
  localparam int PL_DEPTH  = 1 << PL_ADDR_W;
  localparam int PL_DATA_W = 8;

  localparam logic [PL_DATA_W-1:0] NOP = 8'h00;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_RELEASE,
    ST_RUN
  } state_t;

endpackage

// File: rtl/prog_store.sv
// rtl/prog_store.sv - DEPTH x DATA_W flop program store, async clear, comb read
module prog_store #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/prog_loader_rom.sv
// rtl/prog_loader_rom.sv - loads the program store while the core is held in reset, then serves fetches
module prog_loader_rom
  import prog_loader_rom_pkg::*;
#(
  parameter int ADDR_W = PL_ADDR_W,
  parameter int DATA_W = PL_DATA_W,
  parameter int DEPTH  = PL_DEPTH
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              load_en,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] instr,
  output logic              cpu_n_reset,
  output logic [ADDR_W:0]   wr_ptr,
  output logic [DATA_W-1:0] checksum,
  output logic              running
);

  localparam logic [ADDR_W:0] L_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] L_ONE  = (ADDR_W+1)'(1);

  state_t            r_state;
  logic [ADDR_W:0]   r_wr_ptr;
  logic [DATA_W-1:0] r_checksum;
  logic              r_cpu_n_reset;
  logic              r_running;

  logic              w_wr_ready;
  logic              w_xfer;
  logic [DATA_W-1:0] w_rdata;

  // Pointer saturates at DEPTH: ready drops, so word 0 is never overwritten.
  assign w_wr_ready = (r_state == ST_LOAD) && (r_wr_ptr < L_FULL);
  assign w_xfer     = wr_valid && w_wr_ready;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_state       <= ST_LOAD;
      r_wr_ptr      <= '0;
      r_checksum    <= '0;
      r_cpu_n_reset <= 1'b0;
      r_running     <= 1'b0;
    end else begin
      case (r_state)
        ST_LOAD: begin
          if (w_xfer) begin
            r_wr_ptr   <= r_wr_ptr + L_ONE;
            r_checksum <= r_checksum ^ wr_data;
          end
          if ((r_wr_ptr == L_FULL) || !load_en) begin
            r_state <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          r_state       <= ST_RUN;
          r_cpu_n_reset <= 1'b1;
          r_running     <= 1'b1;
        end
        ST_RUN: begin
          if (load_en) begin
            r_state       <= ST_LOAD;
            r_wr_ptr      <= '0;
            r_checksum    <= '0;
            r_cpu_n_reset <= 1'b0;
            r_running     <= 1'b0;
          end
        end
        default: r_state <= ST_LOAD;
      endcase
    end
  end

  prog_store #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_store (
    .clk     (clk),
    .n_reset (n_reset),
    .we      (w_xfer),
    .waddr   (r_wr_ptr[ADDR_W-1:0]),
    .wdata   (wr_data),
    .raddr   (address),
    .rdata   (w_rdata)
  );

  assign instr       = (r_state == ST_RUN) ? w_rdata : NOP;
  assign wr_ready    = w_wr_ready;
  assign cpu_n_reset = r_cpu_n_reset;
  assign wr_ptr      = r_wr_ptr;
  assign checksum    = r_checksum;
  assign running     = r_running;

endmodule

// File: tb/tb_prog_loader_rom.sv
// tb/tb_prog_loader_rom.sv - directed and randomized checks of prog_loader_rom against a reference model
module tb_prog_loader_rom;

  logic       clk = 1'b0;
  logic       n_reset;
  logic       load_en;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic [3:0] address;
  logic [7:0] instr;
  logic       cpu_n_reset;
  logic [4:0] wr_ptr;
  logic [7:0] checksum;
  logic       running;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] m_mem [16];
  int         m_cnt;
  logic [7:0] m_cks;
  int         m_ph;

  localparam int PH_LOAD = 0;
  localparam int PH_REL  = 1;
  localparam int PH_RUN  = 2;

  prog_loader_rom dut (
    .clk         (clk),
    .n_reset     (n_reset),
    .load_en     (load_en),
    .wr_valid    (wr_valid),
    .wr_data     (wr_data),
    .wr_ready    (wr_ready),
    .address     (address),
    .instr       (instr),
    .cpu_n_reset (cpu_n_reset),
    .wr_ptr      (wr_ptr),
    .checksum    (checksum),
    .running     (running)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
    m_cnt = 0;
    m_cks = 8'h00;
    m_ph  = PH_LOAD;
  endtask

  task automatic chk_regs();
    chk("wr_ptr", {27'd0, wr_ptr}, m_cnt);
    chk("checksum", {24'd0, checksum}, {24'd0, m_cks});
    chk("cpu_n_reset", {31'd0, cpu_n_reset}, (m_ph == PH_RUN) ? 1 : 0);
    chk("running", {31'd0, running}, (m_ph == PH_RUN) ? 1 : 0);
  endtask

  task automatic cycle(input logic le, input logic v, input logic [7:0] d, input logic [3:0] a);
    logic xfer;
    load_en  = le;
    wr_valid = v;
    wr_data  = d;
    address  = a;
    #1;
    chk("wr_ready", {31'd0, wr_ready}, (m_ph == PH_LOAD && m_cnt < 16) ? 1 : 0);
    chk("instr", {24'd0, instr}, (m_ph == PH_RUN) ? {24'd0, m_mem[a]} : 32'd0);
    xfer = v && (m_ph == PH_LOAD) && (m_cnt < 16);
    @(posedge clk);
    #1;
    if (m_ph == PH_LOAD) begin
      if (m_cnt == 16 || !le) m_ph = PH_REL;
      if (xfer) begin
        m_mem[m_cnt] = d;
        m_cnt++;
        m_cks ^= d;
      end
    end else if (m_ph == PH_REL) begin
      m_ph = PH_RUN;
    end else if (le) begin
      m_ph  = PH_LOAD;
      m_cnt = 0;
      m_cks = 8'h00;
    end
    chk_regs();
  endtask

  // Offers the bytes in order; optionally drops load_en alongside the last offer.
  task automatic load_bytes(input logic [7:0] q[$], input bit gaps, input bit drop);
    int idx = 0;
    int guard = 0;
    logic v;
    logic le;
    while (idx < q.size() && m_ph == PH_LOAD && guard < 200) begin
      v  = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      le = !(drop && v && (idx == q.size() - 1));
      if (v && m_cnt < 16) idx++;
      cycle(le, v, q[(idx > 0 && v) ? idx - 1 : idx], 4'($urandom_range(0, 15)));
      guard++;
    end
    chk("load_done", idx, q.size());
  endtask

  task automatic settle(input logic le_hold, input logic v_hold);
    int guard = 0;
    while (m_ph != PH_RUN && guard < 8) begin
      cycle((m_ph == PH_LOAD) ? le_hold : 1'b0, v_hold, 8'($urandom), 4'($urandom_range(0, 15)));
      guard++;
    end
    chk("settle_running", {31'd0, running}, 1);
  endtask

  task automatic sweep();
    for (int i = 0; i < 16; i++) cycle(1'b0, 1'($urandom_range(0, 1)), 8'($urandom), 4'(i));
  endtask

  initial begin
    logic [7:0] prog[$];
    logic [7:0] q[$];
    logic [7:0] xr;
    int n;

    prog = '{8'hB7, 8'h01, 8'hE1, 8'h01, 8'hE3, 8'hB6, 8'h01, 8'hE6,
             8'h01, 8'hE8, 8'hB0, 8'hB4, 8'h01, 8'hEA, 8'hB8, 8'hFF};

    n_reset  = 1'b0;
    load_en  = 1'b1;
    wr_valid = 1'b0;
    wr_data  = 8'h00;
    address  = 4'd0;
    model_reset();
    #1;
    chk_regs();
    chk("reset_wr_ready", {31'd0, wr_ready}, 1);
    chk("reset_instr", {24'd0, instr}, 0);
    @(posedge clk);
    #1;
    n_reset = 1'b1;

    // Full load, then backpressure with valid held high
    load_bytes(prog, 1'b0, 1'b0);
    xr = 8'h00;
    foreach (prog[i]) xr ^= prog[i];
    chk("full_checksum", {24'd0, checksum}, {24'd0, xr});
    chk("full_ptr", {27'd0, wr_ptr}, 16);
    settle(1'b1, 1'b1);
    address = 4'd0;
    #1;
    chk("addr0_instr", {24'd0, instr}, 32'hB7);
    address = 4'd15;
    #1;
    chk("addr15_instr", {24'd0, instr}, 32'hFF);
    sweep();

    // Force LOAD, partial load with load_en dropped on the 3rd transfer
    cycle(1'b1, 1'b0, 8'h00, 4'd0);
    q = '{8'hAA, 8'hBB, 8'hCC};
    load_bytes(q, 1'b0, 1'b1);
    chk("partial_ptr", {27'd0, wr_ptr}, 3);
    settle(1'b0, 1'b0);
    address = 4'd2;
    #1;
    chk("partial_idx2", {24'd0, instr}, 32'hCC);
    address = 4'd3;
    #1;
    chk("partial_idx3_old", {24'd0, instr}, 32'h01);
    sweep();

    // Reload from RUN with a single byte
    cycle(1'b1, 1'b0, 8'h00, 4'd0);
    q = '{8'h5A};
    load_bytes(q, 1'b0, 1'b1);
    settle(1'b0, 1'b0);
    address = 4'd0;
    #1;
    chk("reload_idx0", {24'd0, instr}, 32'h5A);
    sweep();

    // Randomized loads with gaps in wr_valid
    for (int r = 0; r < 6; r++) begin
      cycle(1'b1, 1'b0, 8'h00, 4'd0);
      n = $urandom_range(1, 16);
      q = {};
      for (int k = 0; k < n; k++) q.push_back(8'($urandom));
      load_bytes(q, 1'b1, (n < 16) ? 1'b1 : 1'b0);
      settle(1'b1, 1'b1);
      sweep();
    end

    // Async reset mid-load after 5 bytes
    cycle(1'b1, 1'b0, 8'h00, 4'd0);
    q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    load_bytes(q, 1'b0, 1'b0);
    #3;
    n_reset = 1'b0;
    #1;
    model_reset();
    chk_regs();
    chk("midreset_wr_ready", {31'd0, wr_ready}, 1);
    chk("midreset_instr", {24'd0, instr}, 0);
    #1;
    n_reset = 1'b1;
    settle(1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      address = 4'(i);
      #1;
      chk("cleared_mem", {24'd0, instr}, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
